noc_net_interface: RTL and testbench

- Parametrised network interface between a local processing element and the inject/eject port of a mesh Router inside a Node.
- Next-generation replacement for the fixed 20-bit, bufferless PE-to-router path.
- Packs payload plus destination (cluster, local) into single-flit packets and buffers both directions in FIFOs.
- Runs credit-based flow control both ways and keeps a last-read register, flit counters and a sticky error flag.

---
 rtl/noc_net_interface.sv | 130 +++++++++++++
 tb/tb_noc_net_interface.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/noc_net_interface.sv
// PE-side network interface for one router inject/eject port: single-flit packing,
// TX/RX FIFOs, credit-based flow control both directions, counters and sticky error flag.
module noc_net_interface #(
   parameter int DATA_W       = 16,
   parameter int CL_W         = 2,
   parameter int LC_W         = 2,
   parameter int TXQ_DEPTH    = 4,
   parameter int RXQ_DEPTH    = 4,
   parameter int INIT_CREDITS = 4,
   parameter int CNT_W        = 16,
   localparam int FLIT_W      = DATA_W + CL_W + LC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [CL_W-1:0]   tx_cluster,
   input  logic [LC_W-1:0]   tx_local,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [FLIT_W-1:0] inject,
   output logic              inject_valid,
   input  logic              ci,
   input  logic [FLIT_W-1:0] eject,
   input  logic              eject_valid,
   output logic              co,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic [DATA_W-1:0] read,
   output logic [CNT_W-1:0]  tx_count,
   output logic [CNT_W-1:0]  rx_count,
   output logic              overflow
);
   localparam int TA   = $clog2(TXQ_DEPTH);
   localparam int RA   = $clog2(RXQ_DEPTH);
   localparam int CR_W = $clog2(INIT_CREDITS + 1);

   logic [FLIT_W-1:0] tx_mem [TXQ_DEPTH];
   logic [FLIT_W-1:0] rx_mem [RXQ_DEPTH];
   logic [TA:0]       tx_wr_reg, tx_rd_reg;
   logic [RA:0]       rx_wr_reg, rx_rd_reg;
   logic [CR_W-1:0]   credit_reg, credit_next;
   logic              credit_ovf;
   logic [FLIT_W-1:0] inject_reg;
   logic              inject_valid_reg, co_reg, overflow_reg;
   logic [DATA_W-1:0] read_reg;
   logic [CNT_W-1:0]  tx_count_reg, rx_count_reg;

   logic tx_empty, tx_full, tx_push, tx_pop;
   logic rx_empty, rx_full, rx_push, rx_pop, rx_drop;

   // Extra wrap bit on each pointer distinguishes full from empty without losing a slot.
   assign tx_empty = (tx_wr_reg == tx_rd_reg);
   assign tx_full  = (tx_wr_reg[TA] != tx_rd_reg[TA]) && (tx_wr_reg[TA-1:0] == tx_rd_reg[TA-1:0]);
   assign rx_empty = (rx_wr_reg == rx_rd_reg);
   assign rx_full  = (rx_wr_reg[RA] != rx_rd_reg[RA]) && (rx_wr_reg[RA-1:0] == rx_rd_reg[RA-1:0]);

   assign tx_push  = tx_valid && !tx_full;
   // A credit arriving this cycle may be spent immediately.
   assign tx_pop   = !tx_empty && ((credit_reg != '0) || ci);
   assign rx_pop   = !rx_empty && rx_ready;
   assign rx_push  = eject_valid && (!rx_full || rx_pop);
   assign rx_drop  = eject_valid && rx_full && !rx_pop;

   always_comb begin
      credit_next = credit_reg;
      credit_ovf  = 1'b0;
      case ({ci, tx_pop})
         2'b10: begin
            if (credit_reg == CR_W'(INIT_CREDITS)) credit_ovf = 1'b1;
            else credit_next = credit_reg + CR_W'(1);
         end
         2'b01:   credit_next = credit_reg - CR_W'(1);
         default: credit_next = credit_reg;
      endcase
   end

   // Storage carries no reset; the pointers alone define occupancy.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr_reg[TA-1:0]] <= {tx_cluster, tx_local, tx_data};
      if (rx_push) rx_mem[rx_wr_reg[RA-1:0]] <= eject;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_wr_reg        <= '0;
         tx_rd_reg        <= '0;
         rx_wr_reg        <= '0;
         rx_rd_reg        <= '0;
         credit_reg       <= CR_W'(INIT_CREDITS);
         inject_reg       <= '0;
         inject_valid_reg <= 1'b0;
         co_reg           <= 1'b0;
         read_reg         <= '0;
         tx_count_reg     <= '0;
         rx_count_reg     <= '0;
         overflow_reg     <= 1'b0;
      end else begin
         credit_reg       <= credit_next;
         inject_valid_reg <= tx_pop;
         co_reg           <= rx_pop;
         overflow_reg     <= overflow_reg | rx_drop | credit_ovf;
         if (tx_push) tx_wr_reg <= tx_wr_reg + 1'b1;
         if (tx_pop) begin
            tx_rd_reg    <= tx_rd_reg + 1'b1;
            inject_reg   <= tx_mem[tx_rd_reg[TA-1:0]];
            tx_count_reg <= tx_count_reg + CNT_W'(1);
         end
         if (rx_push) begin
            rx_wr_reg    <= rx_wr_reg + 1'b1;
            rx_count_reg <= rx_count_reg + CNT_W'(1);
         end
         if (rx_pop) begin
            rx_rd_reg <= rx_rd_reg + 1'b1;
            read_reg  <= rx_data;
         end
      end
   end

   assign tx_ready     = !tx_full;
   assign rx_valid     = !rx_empty;
   assign rx_data      = rx_mem[rx_rd_reg[RA-1:0]][DATA_W-1:0];
   assign inject       = inject_reg;
   assign inject_valid = inject_valid_reg;
   assign co           = co_reg;
   assign read         = read_reg;
   assign tx_count     = tx_count_reg;
   assign rx_count     = rx_count_reg;
   assign overflow     = overflow_reg;
endmodule

// File: tb/tb_noc_net_interface.sv
// Directed bench for noc_net_interface: injection/credits, eject/pop, overflow and async reset.
module tb_noc_net_interface;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] tx_data;
   logic [1:0]  tx_cluster, tx_local;
   logic        tx_valid, tx_ready;
   logic [19:0] inject;
   logic        inject_valid, ci;
   logic [19:0] eject;
   logic        eject_valid, co;
   logic [15:0] rx_data;
   logic        rx_valid, rx_ready;
   logic [15:0] read;
   logic [15:0] tx_count, rx_count;
   logic        overflow;

   int n_cmp = 0;
   int n_bad = 0;
   int inj_cnt = 0;
   logic [19:0] inj_log [32];

   noc_net_interface dut (
      .clk(clk), .rst(rst),
      .tx_data(tx_data), .tx_cluster(tx_cluster), .tx_local(tx_local),
      .tx_valid(tx_valid), .tx_ready(tx_ready),
      .inject(inject), .inject_valid(inject_valid), .ci(ci),
      .eject(eject), .eject_valid(eject_valid), .co(co),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .read(read), .tx_count(tx_count), .rx_count(rx_count), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   // One clock; outputs are sampled 1 time unit after the edge, injections are logged.
   task automatic tick();
      @(posedge clk);
      #1;
      if (inject_valid) begin
         if (inj_cnt < 32) inj_log[inj_cnt] = inject;
         inj_cnt++;
      end
   endtask

   task automatic push(input logic [15:0] d, input logic [1:0] cl, input logic [1:0] lc);
      tx_valid = 1'b1; tx_data = d; tx_cluster = cl; tx_local = lc;
      tick();
      tx_valid = 1'b0;
   endtask

   task automatic do_reset();
      #2 rst = 1'b1;
      @(posedge clk);
      #3 rst = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int acc;
      rst = 1'b1; tx_data = '0; tx_cluster = '0; tx_local = '0; tx_valid = 1'b0;
      ci = 1'b0; eject = '0; eject_valid = 1'b0; rx_ready = 1'b0;
      #3;
      chk("rst_inject_valid", 32'(inject_valid), 32'h0);
      @(posedge clk);
      #3 rst = 1'b0;
      tick();
      chk("idle_tx_ready", 32'(tx_ready), 32'h1);
      chk("idle_rx_valid", 32'(rx_valid), 32'h0);
      chk("idle_co", 32'(co), 32'h0);
      chk("idle_read", 32'(read), 32'h0);
      chk("idle_overflow", 32'(overflow), 32'h0);
      chk("idle_tx_count", 32'(tx_count), 32'h0);

      // Five flits to cluster 2 local 1; only four credits.
      inj_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tx_valid = 1'b1; tx_data = 16'(16'h1111 * (i + 1)); tx_cluster = 2'd2; tx_local = 2'd1;
         tick();
      end
      tx_valid = 1'b0;
      repeat (3) tick();
      chk("burst_inj_cnt", 32'(inj_cnt), 32'd4);
      chk("burst_first", 32'(inj_log[0]), 32'h91111);
      chk("burst_fourth", 32'(inj_log[3]), 32'h94444);
      chk("burst_tx_count", 32'(tx_count), 32'd4);
      ci = 1'b1; tick(); ci = 1'b0;
      chk("ci_release_valid", 32'(inject_valid), 32'h1);
      chk("ci_release_flit", 32'(inject), 32'h95555);
      chk("ci_release_count", 32'(tx_count), 32'd5);

      // Credits must still be zero after the ci+inject cycle.
      push(16'h6666, 2'd2, 2'd1);
      repeat (3) tick();
      chk("zero_credit_hold", 32'(inj_cnt), 32'd5);
      ci = 1'b1; tick(); ci = 1'b0;
      chk("zero_credit_ci_flit", 32'(inject), 32'h96666);

      // TX FIFO holds exactly TXQ_DEPTH entries.
      acc = 0;
      tx_valid = 1'b1; tx_cluster = 2'd0; tx_local = 2'd0;
      for (int k = 0; k < 8; k++) begin
         if (!tx_ready) break;
         tx_data = 16'(16'h7000 + k);
         tick();
         acc++;
      end
      tx_valid = 1'b0;
      chk("txq_accepted", 32'(acc), 32'd4);
      chk("txq_full_ready", 32'(tx_ready), 32'h0);
      ci = 1'b1; repeat (4) tick(); ci = 1'b0;
      chk("txq_drain_cnt", 32'(inj_cnt), 32'd10);
      chk("txq_drain_last", 32'(inject), 32'h07003);
      ci = 1'b1; repeat (4) tick(); ci = 1'b0;
      chk("credit_refill_ovf", 32'(overflow), 32'h0);
      ci = 1'b1; tick(); ci = 1'b0;
      chk("credit_excess_ovf", 32'(overflow), 32'h1);

      do_reset();
      chk("reset_clears_ovf", 32'(overflow), 32'h0);

      // Fill RX, then eject and pop together while full.
      for (int i = 0; i < 4; i++) begin
         eject_valid = 1'b1; eject = {2'd1, 2'd2, 16'(16'hA000 + i)};
         tick();
         if (i == 0) chk("eject_latency", 32'(rx_valid), 32'h1);
      end
      eject_valid = 1'b0;
      chk("rx_fill_count", 32'(rx_count), 32'd4);
      chk("rx_fill_head", 32'(rx_data), 32'hA000);
      eject_valid = 1'b1; eject = {2'd1, 2'd2, 16'hA004}; rx_ready = 1'b1;
      tick();
      eject_valid = 1'b0; rx_ready = 1'b0;
      chk("full_swap_ovf", 32'(overflow), 32'h0);
      chk("full_swap_count", 32'(rx_count), 32'd5);
      chk("full_swap_co", 32'(co), 32'h1);
      chk("full_swap_read", 32'(read), 32'hA000);
      tick();
      chk("full_swap_co_off", 32'(co), 32'h0);
      rx_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         chk("drain_head", 32'(rx_data), 32'(16'hA000 + i));
         tick();
      end
      rx_ready = 1'b0;
      chk("drain_empty", 32'(rx_valid), 32'h0);
      chk("drain_read", 32'(read), 32'hA004);
      tick();

      // Five ejects into a four-deep RX with no pops.
      for (int i = 0; i < 5; i++) begin
         eject_valid = 1'b1; eject = {2'd3, 2'd0, 16'(16'hB000 + i)};
         tick();
      end
      eject_valid = 1'b0;
      chk("ovf_count", 32'(rx_count), 32'd9);
      chk("ovf_flag", 32'(overflow), 32'h1);
      chk("ovf_head", 32'(rx_data), 32'hB000);
      rx_ready = 1'b1; tick(); rx_ready = 1'b0;
      chk("pop_co", 32'(co), 32'h1);
      chk("pop_read", 32'(read), 32'hB000);
      tick();
      chk("pop_co_off", 32'(co), 32'h0);

      // Async reset mid-burst: three injections spent, one credit left.
      do_reset();
      inj_cnt = 0;
      tx_valid = 1'b1; tx_cluster = 2'd1; tx_local = 2'd3;
      for (int i = 0; i < 4; i++) begin
         tx_data = 16'(16'hC000 + i);
         tick();
      end
      chk("midburst_valid", 32'(inject_valid), 32'h1);
      chk("midburst_flit", 32'(inject), 32'h7C002);
      #2 rst = 1'b1;
      #1;
      chk("async_inject_valid", 32'(inject_valid), 32'h0);
      chk("async_inject", 32'(inject), 32'h0);
      chk("async_tx_count", 32'(tx_count), 32'h0);
      chk("async_overflow", 32'(overflow), 32'h0);
      chk("async_read", 32'(read), 32'h0);
      chk("async_rx_count", 32'(rx_count), 32'h0);
      tx_valid = 1'b0;
      @(posedge clk);
      #3 rst = 1'b0;
      inj_cnt = 0;
      repeat (3) tick();
      chk("no_stale_inject", 32'(inj_cnt), 32'd0);
      for (int i = 0; i < 6; i++) push(16'(16'hD000 + i), 2'd0, 2'd2);
      repeat (3) tick();
      chk("post_reset_credits", 32'(inj_cnt), 32'd4);
      chk("post_reset_last", 32'(inj_log[3]), 32'h2D003);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
